// File: rtl/spi_mem_loader.sv
// SPI frame parser that loads the act/param/inst memories over their external write ports.
// Ports: clk/reset, frame_start/frame_end/rx_valid/rx_byte in; per-memory wren/addr/data, sel_ext, busy, error flags, words_written out.
module spi_mem_loader #(
    parameter int          WIDTH_ACT_MEM    = 8,
    parameter int          WIDTH_ADDR_ACT   = 12,
    parameter int          DEPTH_ACT_MEM    = 4096,
    parameter int          WIDTH_PARAM_MEM  = 128,
    parameter int          WIDTH_ADDR_PARAM = 13,
    parameter int          DEPTH_PARAM_MEM  = 7000,
    parameter int          WIDTH_INST_MEM   = 80,
    parameter int          WIDTH_ADDR_INST  = 6,
    parameter int          DEPTH_INST_MEM   = 64,
    parameter logic [1:0]  ACT_MEM_HEADER   = 2'b10,
    parameter logic [1:0]  PARAM_MEM_HEADER = 2'b01,
    parameter logic [1:0]  INST_MEM_HEADER  = 2'b11
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        frame_start,
    input  logic                        frame_end,
    input  logic                        rx_valid,
    input  logic [7:0]                  rx_byte,
    output logic                        act_mem_wren,
    output logic [WIDTH_ADDR_ACT-1:0]   act_mem_addr,
    output logic [WIDTH_ACT_MEM-1:0]    act_mem_data,
    output logic                        param_mem_wren,
    output logic [WIDTH_ADDR_PARAM-1:0] param_mem_addr,
    output logic [WIDTH_PARAM_MEM-1:0]  param_mem_data,
    output logic                        inst_mem_wren,
    output logic [WIDTH_ADDR_INST-1:0]  inst_mem_addr,
    output logic [WIDTH_INST_MEM-1:0]   inst_mem_data,
    output logic                        sel_ext,
    output logic                        busy,
    output logic                        err_hdr,
    output logic                        err_partial,
    output logic                        err_range,
    output logic [15:0]                 words_written
);

    localparam int B_ACT   = (WIDTH_ACT_MEM + 7) / 8;
    localparam int B_PARAM = (WIDTH_PARAM_MEM + 7) / 8;
    localparam int B_INST  = (WIDTH_INST_MEM + 7) / 8;
    localparam int B_PI    = (B_PARAM > B_INST) ? B_PARAM : B_INST;
    localparam int B_MAX   = (B_PI > B_ACT) ? B_PI : B_ACT;
    localparam int SHW     = 8 * B_MAX;

    typedef enum logic [2:0] {
        S_IDLE, S_HDR, S_ADDR_HI, S_ADDR_LO, S_DATA, S_DISCARD
    } state_t;

    state_t r_state, w_next;
    logic                        r_sel;
    logic [1:0]                  r_tgt;
    logic [15:0]                 r_addr;
    logic [SHW-1:0]              r_shift;
    logic [7:0]                  r_cnt;
    logic                        r_supp;
    logic                        r_err_hdr, r_err_partial, r_err_range;
    logic [15:0]                 r_words;
    logic                        r_act_wren, r_param_wren, r_inst_wren;
    logic [WIDTH_ADDR_ACT-1:0]   r_act_addr;
    logic [WIDTH_ACT_MEM-1:0]    r_act_data;
    logic [WIDTH_ADDR_PARAM-1:0] r_param_addr;
    logic [WIDTH_PARAM_MEM-1:0]  r_param_data;
    logic [WIDTH_ADDR_INST-1:0]  r_inst_addr;
    logic [WIDTH_INST_MEM-1:0]   r_inst_data;

    logic [7:0]     w_bcur;
    logic [16:0]    w_depth;
    logic [16:0]    w_addr_inc;
    logic [1:0]     w_hdr;
    logic           w_hdr_ok;
    logic           w_last;
    logic [7:0]     w_cnt_after;
    logic [SHW-1:0] w_word;

    // Only the low W bits of the shift window are kept, which drops the
    // unused upper bits of a word's first byte.
    assign w_word     = {r_shift[SHW-9:0], rx_byte};
    assign w_addr_inc = {1'b0, r_addr} + 17'd1;
    assign w_hdr      = rx_byte[7:6];

    always_comb begin
        w_bcur  = 8'(B_ACT);
        w_depth = 17'(DEPTH_ACT_MEM);
        if (r_tgt == PARAM_MEM_HEADER) begin
            w_bcur  = 8'(B_PARAM);
            w_depth = 17'(DEPTH_PARAM_MEM);
        end else if (r_tgt == INST_MEM_HEADER) begin
            w_bcur  = 8'(B_INST);
            w_depth = 17'(DEPTH_INST_MEM);
        end
        w_hdr_ok = (w_hdr != 2'b00) &&
                   ((w_hdr == ACT_MEM_HEADER) ||
                    (w_hdr == PARAM_MEM_HEADER) ||
                    (w_hdr == INST_MEM_HEADER));
        w_last      = (r_cnt == w_bcur - 8'd1);
        w_cnt_after = r_cnt;
        if (r_state == S_DATA && rx_valid)
            w_cnt_after = w_last ? 8'd0 : r_cnt + 8'd1;

        w_next = r_state;
        case (r_state)
            S_HDR:     if (rx_valid) w_next = w_hdr_ok ? S_ADDR_HI : S_DISCARD;
            S_ADDR_HI: if (rx_valid) w_next = S_ADDR_LO;
            S_ADDR_LO: if (rx_valid) w_next = S_DATA;
            default:   w_next = r_state;
        endcase
        if (frame_end)   w_next = S_IDLE;
        if (frame_start) w_next = S_HDR;
    end

    // sel_ext is held one extra cycle after the frame closes so a write
    // issued by the closing byte still lands on the external ports.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_sel   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_sel   <= (w_next != S_IDLE) || (r_state != S_IDLE);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tgt         <= 2'b00;
            r_addr        <= '0;
            r_shift       <= '0;
            r_cnt         <= '0;
            r_supp        <= 1'b0;
            r_err_hdr     <= 1'b0;
            r_err_partial <= 1'b0;
            r_err_range   <= 1'b0;
            r_words       <= '0;
            r_act_wren    <= 1'b0;
            r_param_wren  <= 1'b0;
            r_inst_wren   <= 1'b0;
            r_act_addr    <= '0;
            r_act_data    <= '0;
            r_param_addr  <= '0;
            r_param_data  <= '0;
            r_inst_addr   <= '0;
            r_inst_data   <= '0;
        end else begin
            r_act_wren   <= 1'b0;
            r_param_wren <= 1'b0;
            r_inst_wren  <= 1'b0;
            if (frame_start) begin
                r_cnt   <= '0;
                r_supp  <= 1'b0;
                r_words <= '0;
                if (r_state == S_IDLE) begin
                    r_err_hdr     <= 1'b0;
                    r_err_partial <= 1'b0;
                    r_err_range   <= 1'b0;
                end else if (r_state == S_DATA && r_cnt != 8'd0) begin
                    r_err_partial <= 1'b1;
                end
            end else begin
                if (rx_valid) begin
                    case (r_state)
                        S_HDR: begin
                            r_tgt <= w_hdr;
                            if (!w_hdr_ok) r_err_hdr <= 1'b1;
                        end
                        S_ADDR_HI: r_addr[15:8] <= rx_byte;
                        S_ADDR_LO: begin
                            r_addr[7:0] <= rx_byte;
                            r_cnt       <= '0;
                            if ({1'b0, r_addr[15:8], rx_byte} >= w_depth) begin
                                r_err_range <= 1'b1;
                                r_supp      <= 1'b1;
                            end
                        end
                        S_DATA: begin
                            r_shift <= w_word;
                            r_cnt   <= w_cnt_after;
                            if (w_last && !r_supp) begin
                                if (r_tgt == ACT_MEM_HEADER) begin
                                    r_act_wren <= 1'b1;
                                    r_act_addr <= r_addr[WIDTH_ADDR_ACT-1:0];
                                    r_act_data <= w_word[WIDTH_ACT_MEM-1:0];
                                end else if (r_tgt == PARAM_MEM_HEADER) begin
                                    r_param_wren <= 1'b1;
                                    r_param_addr <= r_addr[WIDTH_ADDR_PARAM-1:0];
                                    r_param_data <= w_word[WIDTH_PARAM_MEM-1:0];
                                end else begin
                                    r_inst_wren <= 1'b1;
                                    r_inst_addr <= r_addr[WIDTH_ADDR_INST-1:0];
                                    r_inst_data <= w_word[WIDTH_INST_MEM-1:0];
                                end
                                r_addr <= r_addr + 16'd1;
                                if (r_words != 16'hFFFF) r_words <= r_words + 16'd1;
                                // Reaching the end of memory stops the frame; no wrap.
                                if (w_addr_inc == w_depth) begin
                                    r_err_range <= 1'b1;
                                    r_supp      <= 1'b1;
                                end
                            end
                        end
                        default: ;
                    endcase
                end
                // Partial count is taken after a same-cycle byte is absorbed.
                if (frame_end && r_state == S_DATA && w_cnt_after != 8'd0)
                    r_err_partial <= 1'b1;
            end
        end
    end

    assign act_mem_wren   = r_act_wren;
    assign act_mem_addr   = r_act_addr;
    assign act_mem_data   = r_act_data;
    assign param_mem_wren = r_param_wren;
    assign param_mem_addr = r_param_addr;
    assign param_mem_data = r_param_data;
    assign inst_mem_wren  = r_inst_wren;
    assign inst_mem_addr  = r_inst_addr;
    assign inst_mem_data  = r_inst_data;
    assign sel_ext        = r_sel;
    assign busy           = (r_state != S_IDLE);
    assign err_hdr        = r_err_hdr;
    assign err_partial    = r_err_partial;
    assign err_range      = r_err_range;
    assign words_written  = r_words;

endmodule

// File: doc/spi_mem_loader.md
Name: spi_mem_loader

Overview:
- Sits between the SPI byte receiver and the processor's external memory write ports (act/param/inst).
- Parses framed SPI byte streams: header byte, 16-bit start address, then payload.
- Packs payload bytes MSB-first into memory-width words and issues one single-cycle write per word with an auto-incrementing address.
- Holds sel_ext high while a frame is active so the processor's memories take the external ports.

Parameters:
- WIDTH_ACT_MEM, 8, act memory word width (bits)
- WIDTH_ADDR_ACT, 12, act address width
- DEPTH_ACT_MEM, 4096, act words
- WIDTH_PARAM_MEM, 128, param word width
- WIDTH_ADDR_PARAM, 13, param address width
- DEPTH_PARAM_MEM, 7000, param words
- WIDTH_INST_MEM, 80, inst word width
- WIDTH_ADDR_INST, 6, inst address width
- DEPTH_INST_MEM, 64, inst words
- ACT_MEM_HEADER, 2'b10, header code for act memory
- PARAM_MEM_HEADER, 2'b01, header code for param memory
- INST_MEM_HEADER, 2'b11, header code for inst memory

Ports:
- clk  in  1  single clock; one clock domain, all logic on rising edge
- reset  in  1  synchronous, active-high
- frame_start  in  1  one-cycle pulse at chip-select assertion
- frame_end  in  1  one-cycle pulse at chip-select deassertion
- rx_valid  in  1  rx_byte valid this cycle (1-cycle pulse)
- rx_byte  in  8  received byte
- act_mem_wren / act_mem_addr / act_mem_data  out  1 / WIDTH_ADDR_ACT / WIDTH_ACT_MEM
- param_mem_wren / param_mem_addr / param_mem_data  out  1 / WIDTH_ADDR_PARAM / WIDTH_PARAM_MEM
- inst_mem_wren / inst_mem_addr / inst_mem_data  out  1 / WIDTH_ADDR_INST / WIDTH_INST_MEM
- sel_ext  out  1  high from HDR through end of frame
- busy  out  1  state != IDLE
- err_hdr, err_partial, err_range  out  1 each  sticky error flags
- words_written  out  16  words written in the current or last frame (saturates at 0xFFFF)

Behaviour:
- Reset: state IDLE; all wren, addr, data, sel_ext, busy, error flags and words_written are 0. Reset during a frame aborts it with no further writes.
- States:
  - IDLE: frame_start -> HDR.
  - HDR: on rx_valid, rx_byte[7:6] selects the target; bits [5:0] are ignored. A match -> ADDR_HI. 2'b00 or no match -> DISCARD and set err_hdr.
  - ADDR_HI: on rx_valid, latch addr[15:8] -> ADDR_LO.
  - ADDR_LO: on rx_valid, latch addr[7:0] -> DATA. If the 16-bit address >= target DEPTH, set err_range and suppress all writes this frame.
  - DATA: shift in bytes MSB-first. Bytes per word B = ceil(W/8): act 1, param 16, inst 10. When W is not a multiple of 8, the first byte's upper (8B-W) bits are dropped.
  - DISCARD: ignore bytes until frame_end.
- Write timing: the registered wren pulses high exactly one cycle after the rx_valid of a word's last byte. addr/data are valid in the same cycle. Exactly one wren is asserted at a time; wren is never high for two consecutive cycles unless rx_valid was.
- Address handling: after each write, addr+1. If addr+1 == DEPTH, set err_range and suppress later writes in the frame; there is no wrap.
- frame_end (any state) -> IDLE.
  - A nonzero partial byte count in DATA sets err_partial; the partial word is discarded.
  - rx_valid and frame_end in the same cycle: the byte is processed first, including a resulting write, then the frame closes.
- frame_start while not IDLE: the current frame is aborted. A pending partial word sets err_partial. Go to HDR.
- frame_start in IDLE clears all error flags and words_written. A frame_start that aborts a frame clears only words_written; err_partial from the abort remains visible.
- sel_ext deasserts the cycle after entering IDLE, so the final write completes with sel_ext high.
- rx_valid in IDLE is ignored.

Test Plan:
- Act frame: start, bytes 0x80, 0x00, 0x05, 0xAA, 0xBB, end -> act writes (addr 5, data 0xAA) then (6, 0xBB), one cycle after each byte; words_written = 2; no errors.
- Param frame: header 0x40, addr 0x0010, bytes 0x00..0x0F -> a single param write at addr 16 with data 0x000102...0F, one cycle after the 16th byte.
- Inst frame: header 0xC0, addr 63, 20 bytes -> one inst write at addr 63; err_range set; the second word is suppressed; words_written = 1.
- Bad header 0x00 plus 5 bytes -> err_hdr = 1, no wren, busy until frame_end; the next frame_start clears err_hdr.
- Param frame with 7 payload bytes then frame_end -> no write, err_partial = 1; abort by a mid-frame frame_start -> same, then the new frame parses normally.
- Reset asserted mid-param-word -> all outputs 0 next cycle; a subsequent act frame writes correctly.
